// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word, opcode and write-mask types
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

endpackage

// File: rtl/lc3b_mem_seq_if.sv
// rtl/lc3b_mem_seq_if.sv - word-organised memory port between sequencer and memory
interface lc3b_mem_seq_if;
   import lc3b_types::*;

   logic          mem_read;
   logic          mem_write;
   lc3b_word      mem_address;
   lc3b_word      mem_wdata;
   lc3b_mem_wmask mem_byte_enable;
   logic          mem_resp;
   lc3b_word      mem_rdata;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_resp, mem_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_resp, mem_rdata
   );
endinterface

// File: rtl/lc3b_mem_seq.sv
// rtl/lc3b_mem_seq.sv - multi-cycle LC-3b load/store sequencer with indirect and byte accesses
module lc3b_mem_seq
   import lc3b_types::*;
#(
   parameter bit LDB_SEXT = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req,
   input  lc3b_opcode     op,
   input  lc3b_word       addr,
   input  lc3b_word       wdata,
   output logic           busy,
   output logic           done,
   output logic           err,
   output lc3b_word       rdata,
   lc3b_mem_seq_if.master mem
);

   typedef enum logic [1:0] {IDLE, PTR, ACC, DONE} state_t;

   state_t     state, state_nxt;
   lc3b_opcode op_q;
   lc3b_word   addr_q;
   lc3b_word   wdata_q;
   logic       err_q;

   logic       op_is_mem;
   logic       is_load;
   logic       is_store;
   logic       is_byte;
   logic [7:0] byte_sel;

   always_comb begin
      op_is_mem = 1'b0;
      case (op)
         op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti: op_is_mem = 1'b1;
         default:                                         op_is_mem = 1'b0;
      endcase
      is_load  = (op_q == op_ldr) || (op_q == op_ldb) || (op_q == op_ldi);
      is_store = (op_q == op_str) || (op_q == op_stb) || (op_q == op_sti);
      is_byte  = (op_q == op_ldb) || (op_q == op_stb);
      byte_sel = addr_q[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               case (op)
                  op_ldi, op_sti:                 state_nxt = PTR;
                  op_ldr, op_ldb, op_str, op_stb: state_nxt = ACC;
                  default:                        state_nxt = DONE;
               endcase
            end
         end
         PTR:     if (mem.mem_resp) state_nxt = ACC;
         ACC:     if (mem.mem_resp) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes depend only on registered state; address/data come from the capture registers.
   always_comb begin
      busy                = (state != IDLE);
      done                = (state == DONE);
      err                 = (state == DONE) && err_q;
      mem.mem_read        = (state == PTR) || ((state == ACC) && is_load);
      mem.mem_write       = (state == ACC) && is_store;
      mem.mem_address     = {addr_q[15:1], 1'b0};
      mem.mem_wdata       = wdata_q;
      mem.mem_byte_enable = 2'b00;
      if (state == ACC) begin
         if (is_byte) begin
            mem.mem_address     = addr_q;
            mem.mem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
            mem.mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
         end else begin
            mem.mem_byte_enable = 2'b11;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_q    <= op_br;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req) begin
                  op_q    <= op;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  err_q   <= !op_is_mem;
               end
            end
            PTR: begin
               if (mem.mem_resp) addr_q <= mem.mem_rdata;
            end
            ACC: begin
               if (mem.mem_resp && is_load) begin
                  if (is_byte)
                     rdata <= {{8{LDB_SEXT & byte_sel[7]}}, byte_sel};
                  else
                     rdata <= mem.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_mem_seq.sv
// tb/tb_lc3b_mem_seq.sv - scoreboard bench for the LC-3b memory access sequencer
module tb_lc3b_mem_seq;
   import lc3b_types::*;

   typedef struct packed {
      lc3b_word rd;
      logic     er;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   lc3b_opcode op = op_br;
   lc3b_word   addr = '0;
   lc3b_word   wdata = '0;

   logic       busy0, done0, err0, busy1, done1, err1;
   lc3b_word   rdata0, rdata1;

   lc3b_mem_seq_if m0 ();
   lc3b_mem_seq_if m1 ();

   lc3b_mem_seq #(.LDB_SEXT(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy0), .done(done0), .err(err0), .rdata(rdata0), .mem(m0.master)
   );

   lc3b_mem_seq #(.LDB_SEXT(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy1), .done(done1), .err(err1), .rdata(rdata1), .mem(m1.master)
   );

   always #5 clk = ~clk;

   int       n_cmp = 0;
   int       n_bad = 0;
   exp_t     sb_q[$];
   lc3b_word mem[int];
   int       waits0 = 0;
   int       cnt0 = 0;
   bit       stray = 1'b0;

   int       lat;
   int       n_strobe;
   lc3b_word first_addr, last_addr, wr_data;
   logic [1:0] wr_be;
   bit       saw_write;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic lc3b_word mem_rd(input lc3b_word a);
      int k;
      k = int'({a[15:1], 1'b0});
      return mem.exists(k) ? mem[k] : 16'h0000;
   endfunction

   task automatic mem_wr(input lc3b_word a, input lc3b_word d, input logic [1:0] be);
      lc3b_word w;
      w = mem_rd(a);
      if (be[0]) w[7:0]  = d[7:0];
      if (be[1]) w[15:8] = d[15:8];
      mem[int'({a[15:1], 1'b0})] = w;
   endtask

   // Memory behind dut0: configurable wait states, one-cycle response, optional stray response.
   initial begin
      logic was;
      m0.mem_resp  = 1'b0;
      m0.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         was = m0.mem_resp;
         m0.mem_resp = 1'b0;
         if (was) cnt0 = 0;
         if (m0.mem_read || m0.mem_write) begin
            if (cnt0 == waits0) begin
               m0.mem_resp = 1'b1;
               if (m0.mem_read) m0.mem_rdata = mem_rd(m0.mem_address);
               else mem_wr(m0.mem_address, m0.mem_wdata, m0.mem_byte_enable);
            end else begin
               cnt0++;
            end
         end else begin
            cnt0 = 0;
            if (stray) begin
               m0.mem_resp  = 1'b1;
               m0.mem_rdata = 16'hDEAD;
               stray = 1'b0;
            end
         end
      end
   end

   // Memory behind dut1: zero wait states, read-only view of the same array.
   initial begin
      m1.mem_resp  = 1'b0;
      m1.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         m1.mem_resp = m1.mem_read || m1.mem_write;
         if (m1.mem_read) m1.mem_rdata = mem_rd(m1.mem_address);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done0) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("sb_rdata", rdata0, e.rd);
               check("sb_err", err0, e.er);
            end
         end
      end
   end

   task automatic access(input string tag, input lc3b_opcode o, input lc3b_word a,
                         input lc3b_word d, input int w, input bit with_stray,
                         input lc3b_word exp_rd, input logic exp_er, input int exp_lat);
      int t;
      t = 0;
      while ((busy0 || busy1) && t < 100) begin
         @(negedge clk);
         t++;
      end
      waits0 = w;
      if (with_stray) begin
         stray = 1'b1;
         @(posedge clk);
         #2;
      end
      @(negedge clk);
      req = 1'b1; op = o; addr = a; wdata = d;
      sb_q.push_back('{rd: exp_rd, er: exp_er});
      @(posedge clk);
      #1;
      req = 1'b0;
      lat = 1; n_strobe = 0; saw_write = 1'b0;
      first_addr = '0; last_addr = '0; wr_data = '0; wr_be = 2'b00;
      t = 0;
      while (!done0 && t < 60) begin
         if (m0.mem_read || m0.mem_write) begin
            if (n_strobe == 0) first_addr = m0.mem_address;
            last_addr = m0.mem_address;
            n_strobe++;
            if (m0.mem_write) begin
               saw_write = 1'b1;
               wr_data = m0.mem_wdata;
               wr_be = m0.mem_byte_enable;
            end
         end
         @(posedge clk);
         #1;
         lat++;
         t++;
      end
      if (t >= 60) check({tag, "_timeout"}, 0, 1);
      else check({tag, "_latency"}, lat, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      mem[16'h1234] = 16'hBEEF;
      mem[16'h2000] = 16'h80AA;
      mem[16'h4000] = 16'h5006;
      mem[16'h5006] = 16'h00C3;
      mem[16'h7000] = 16'h6001;

      repeat (2) @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_err", err0, 0);
      check("rst_rdata", rdata0, 16'h0000);
      check("rst_mem_read", m0.mem_read, 0);
      check("rst_mem_write", m0.mem_write, 0);
      check("rst_byte_enable", m0.mem_byte_enable, 2'b00);
      check("rst_mem_address", m0.mem_address, 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      access("ldr", op_ldr, 16'h1235, 16'h0000, 3, 1'b0, 16'hBEEF, 1'b0, 5);
      check("ldr_first_addr", first_addr, 16'h1234);
      check("ldr_last_addr", last_addr, 16'h1234);
      check("ldr_strobe_cycles", n_strobe, 4);

      access("ldb_hi", op_ldb, 16'h2001, 16'h0000, 0, 1'b0, 16'hFF80, 1'b0, 2);
      check("ldb_hi_addr", last_addr, 16'h2001);
      t = 0;
      while (!done1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ldb_zext_rdata", rdata1, 16'h0080);

      access("ldb_lo", op_ldb, 16'h2000, 16'h0000, 0, 1'b0, 16'hFFAA, 1'b0, 2);

      access("stb", op_stb, 16'h3003, 16'h1234, 0, 1'b0, 16'hFFAA, 1'b0, 2);
      check("stb_write", saw_write, 1);
      check("stb_byte_enable", wr_be, 2'b10);
      check("stb_wdata", wr_data, 16'h3434);
      check("stb_mem", mem_rd(16'h3002), 16'h3400);

      access("ldi", op_ldi, 16'h4000, 16'h0000, 0, 1'b0, 16'h00C3, 1'b0, 3);
      check("ldi_ptr_addr", first_addr, 16'h4000);
      check("ldi_acc_addr", last_addr, 16'h5006);

      access("bad_op", op_add, 16'h1111, 16'hFFFF, 0, 1'b0, 16'h00C3, 1'b1, 1);
      check("bad_op_strobes", n_strobe, 0);

      access("sti", op_sti, 16'h7000, 16'h55AA, 0, 1'b0, 16'h00C3, 1'b0, 3);
      check("sti_acc_addr", last_addr, 16'h6000);
      check("sti_mem", mem_rd(16'h6000), 16'h55AA);

      // Abort a long-wait load in ACC with an asynchronous reset.
      t = 0;
      while ((busy0 || busy1) && t < 100) begin
         @(negedge clk);
         t++;
      end
      waits0 = 20;
      @(negedge clk);
      req = 1'b1; op = op_ldr; addr = 16'h1235;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_read_before", m0.mem_read, 1);
      rst_n = 1'b0;
      #1;
      check("abort_read_after", m0.mem_read, 0);
      check("abort_busy", busy0, 0);
      check("abort_rdata", rdata0, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      access("stray", op_ldr, 16'h1235, 16'h0000, 0, 1'b1, 16'hBEEF, 1'b0, 2);

      repeat (4) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
